fwd_hazard_tracker: RTL



---
 rtl/fwd_hazard_tracker_if.sv | 36 +++
 rtl/fwd_hazard_tracker.sv | 95 +++++++++
 2 files changed

// File: rtl/fwd_hazard_tracker_if.sv
// Decode-stage hazard tracker bus: issue info, operand sources, pipeline
// control and the resulting forwarding/stall outputs.
interface fwd_hazard_tracker_if #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              issue_valid;
  logic              issue_wr;
  logic [REG_AW-1:0] issue_wadr;
  logic              issue_load;
  logic              src_a_used;
  logic              src_b_used;
  logic [REG_AW-1:0] src_a_adr;
  logic [REG_AW-1:0] src_b_adr;
  logic              hold;
  logic              flush;
  logic [DEPTH-1:0]  fwd_a;
  logic [DEPTH-1:0]  fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output issue_valid, issue_wr, issue_wadr, issue_load,
    output src_a_used, src_b_used, src_a_adr, src_b_adr,
    output hold, flush,
    input  fwd_a, fwd_b, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wr, issue_wadr, issue_load,
    input  src_a_used, src_b_used, src_a_adr, src_b_adr,
    input  hold, flush,
    output fwd_a, fwd_b, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard tracker. Keeps a shift-register history of
// the last DEPTH issued destinations; youngest matching producer is selected
// for forwarding, and a load in the youngest slot forces a one-cycle stall.
module fwd_hazard_tracker #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  fwd_hazard_tracker_if.slave bus
);

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  wr_q;
  logic [DEPTH-1:0]  ld_q;
  logic [REG_AW-1:0] adr_q [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [DEPTH-1:0]  match_a;
  logic [DEPTH-1:0]  match_b;
  logic [DEPTH-1:0]  elig_a;
  logic [DEPTH-1:0]  elig_b;
  logic [DEPTH-1:0]  fwd_a;
  logic [DEPTH-1:0]  fwd_b;
  logic              found_a;
  logic              found_b;
  logic              stall;

  // Operand matching, youngest-wins forwarding select and load-use stall.
  always_comb begin
    match_a = '0;
    match_b = '0;
    fwd_a   = '0;
    fwd_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      match_a[k] = bus.src_a_used & v_q[k] & wr_q[k] & (adr_q[k] == bus.src_a_adr);
      match_b[k] = bus.src_b_used & v_q[k] & wr_q[k] & (adr_q[k] == bus.src_b_adr);
    end
    // A load's data is not available at stage 0, so it cannot be forwarded there.
    elig_a    = match_a;
    elig_b    = match_b;
    elig_a[0] = match_a[0] & ~ld_q[0];
    elig_b[0] = match_b[0] & ~ld_q[0];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (elig_a[k] && !found_a) begin
        fwd_a[k] = 1'b1;
        found_a  = 1'b1;
      end
      if (elig_b[k] && !found_b) begin
        fwd_b[k] = 1'b1;
        found_b  = 1'b1;
      end
    end
    stall = bus.issue_valid & ld_q[0] & (match_a[0] | match_b[0]);
  end

  // History shift register and saturating stall counter; flush beats hold beats stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        adr_q[k] <= '0;
      end
    end else if (bus.flush) begin
      v_q <= '0;
    end else if (!bus.hold) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_q[k]   <= v_q[k-1];
        wr_q[k]  <= wr_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        adr_q[k] <= adr_q[k-1];
      end
      // A stalled instruction is replayed, so a bubble takes its slot.
      v_q[0]   <= bus.issue_valid & ~stall;
      wr_q[0]  <= bus.issue_wr;
      ld_q[0]  <= bus.issue_load;
      adr_q[0] <= bus.issue_wadr;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.fwd_a     = fwd_a;
  assign bus.fwd_b     = fwd_b;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
